// File: rtl/branch_resolve_unit_if.sv
// Execute-stage <-> branch resolve unit bundle.
// Ports: master drives ALU status/branch info; slave returns PC/flush/link/stats.
interface branch_resolve_unit_if;
  logic        InstrValid;
  logic [3:0]  BranchType;
  logic        ALUzero;
  logic        MSB;
  logic        ALUc_out;
  logic        CarryWrEn;
  logic        HaltReq;
  logic [31:0] ImmTarget;
  logic [31:0] RegTarget;
  logic [31:0] PC;
  logic        Flush;
  logic        LinkWrEn;
  logic [31:0] LinkData;
  logic        CarryFlag;
  logic        Halted;
  logic [15:0] BrTotal;
  logic [15:0] BrTaken;

  modport master (
    output InstrValid, BranchType, ALUzero, MSB,
    output ALUc_out, CarryWrEn, HaltReq,
    output ImmTarget, RegTarget,
    input  PC, Flush, LinkWrEn, LinkData,
    input  CarryFlag, Halted, BrTotal, BrTaken
  );

  modport slave (
    input  InstrValid, BranchType, ALUzero, MSB,
    input  ALUc_out, CarryWrEn, HaltReq,
    input  ImmTarget, RegTarget,
    output PC, Flush, LinkWrEn, LinkData,
    output CarryFlag, Halted, BrTotal, BrTaken
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carry flag, PC, flush bubbles, bl link data, halt.
// Ports: clk, rst_n (async low), bus (slave). Macro BRANCH_STATS_EN adds counters.
module branch_resolve_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  branch_resolve_unit_if.slave bus
);

  localparam int FlushN =
    (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) ? 1 : FLUSH_CYCLES;
  localparam logic [1:0] CntInit = 2'(FlushN - 1);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  state_t      state;
  logic [1:0]  flushCnt;
  logic [31:0] pc;
  logic        flush;
  logic        linkWrEn;
  logic [31:0] linkData;
  logic        carryFlag;
  logic        halted;

  logic        isB, isBr, isBl, isBltz;
  logic        isBz, isBnz, isBcy, isBncy;
  logic        taken;
  logic [31:0] target;
  logic [31:0] pcPlus4;

  assign isB    = bus.BranchType == 4'b0001;
  assign isBr   = bus.BranchType == 4'b0010;
  assign isBl   = bus.BranchType == 4'b0011;
  assign isBltz = bus.BranchType == 4'b0100;
  assign isBz   = bus.BranchType == 4'b0101;
  assign isBnz  = bus.BranchType == 4'b0110;
  assign isBcy  = bus.BranchType == 4'b0111;
  assign isBncy = bus.BranchType == 4'b1000;

  assign pcPlus4 = pc + 32'd4;

  // bcy/bncy look at the registered flag only.
  always_comb begin
    taken  = 1'b0;
    target = bus.ImmTarget;
    unique case (1'b1)
      isB, isBl: taken = 1'b1;
      isBr: begin
        taken  = 1'b1;
        target = bus.RegTarget;
      end
      isBltz: taken = bus.MSB;
      isBz:   taken = bus.ALUzero;
      isBnz:  taken = ~bus.ALUzero;
      isBcy:  taken = carryFlag;
      isBncy: taken = ~carryFlag;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flushCnt  <= 2'd0;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      linkWrEn  <= 1'b0;
      linkData  <= 32'd0;
      carryFlag <= 1'b0;
      halted    <= 1'b0;
    end else begin
      linkWrEn <= 1'b0;
      unique case (state)
        RUN: begin
          if (bus.InstrValid && bus.CarryWrEn)
            carryFlag <= bus.ALUc_out;
          if (bus.InstrValid && bus.HaltReq) begin
            state  <= HALT;
            halted <= 1'b1;
            pc     <= pcPlus4;
          end else if (bus.InstrValid && taken) begin
            state    <= FLUSH;
            flushCnt <= CntInit;
            flush    <= 1'b1;
            pc       <= target;
            if (isBl) begin
              linkWrEn <= 1'b1;
              linkData <= pcPlus4;
            end
          end else begin
            pc <= pcPlus4;
          end
        end
        FLUSH: begin
          if (flushCnt == 2'd0) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            flushCnt <= flushCnt - 2'd1;
          end
        end
        HALT: halted <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.PC        = pc;
  assign bus.Flush     = flush;
  assign bus.LinkWrEn  = linkWrEn;
  assign bus.LinkData  = linkData;
  assign bus.CarryFlag = carryFlag;
  assign bus.Halted    = halted;

`ifdef BRANCH_STATS_EN
  logic [15:0] brTotal;
  logic [15:0] brTaken;
  logic        resolve;

  // A halting instruction never resolves its branch.
  assign resolve = state == RUN && bus.InstrValid && !bus.HaltReq &&
                   (isB | isBr | isBl | isBltz |
                    isBz | isBnz | isBcy | isBncy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brTotal <= 16'd0;
      brTaken <= 16'd0;
    end else if (resolve) begin
      if (brTotal != 16'hFFFF)
        brTotal <= brTotal + 16'd1;
      if (taken && brTaken != 16'hFFFF)
        brTaken <= brTaken + 16'd1;
    end
  end

  assign bus.BrTotal = brTotal;
  assign bus.BrTaken = brTaken;
`else
  assign bus.BrTotal = 16'd0;
  assign bus.BrTaken = 16'd0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage neighbour directly downstream of the 32-bit ALU.
- Consumes the ALU status outputs: zero, MSB and carry-out.
- Holds the architectural carry flag used by bcy/bncy and owns the program counter.
- Resolves every branch type, generates the flush bubble after a taken branch, and produces link data for bl.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 1, bubble cycles after a taken branch; legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- InstrValid  in  1  execute-stage instruction is valid this cycle.
- BranchType  in  4  branch class: 0000 none, 0001 b, 0010 br, 0011 bl, 0100 bltz, 0101 bz, 0110 bnz, 0111 bcy, 1000 bncy; all other codes behave as none.
- ALUzero  in  1  ALU result equals zero.
- MSB  in  1  ALU result bit 31.
- ALUc_out  in  1  ALU adder carry-out.
- CarryWrEn  in  1  instruction updates the carry flag (add/addi/comp class).
- HaltReq  in  1  halt request from decode.
- ImmTarget  in  32  absolute target for b/bl/bltz/bz/bnz/bcy/bncy.
- RegTarget  in  32  rs value for br.
- PC  out  32  current program counter.
- Flush  out  1  squash fetch/decode this cycle.
- LinkWrEn  out  1  write LinkData to ra (one-cycle pulse).
- LinkData  out  32  PC+4 of the bl instruction.
- CarryFlag  out  1  registered carry flag.
- Halted  out  1  core halted.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; CarryFlag=0; Flush=0; LinkWrEn=0; LinkData=0; Halted=0.
  - State=RUN; flush counter=0.
  - Reset mid-flush or mid-halt returns to RUN immediately.
- States:
  - RUN: PC advances each cycle.
  - FLUSH: bubble cycles after a taken branch.
  - HALT: core stopped.
- RUN, InstrValid=1, resolving the branch (condition evaluated combinationally from same-cycle inputs):
  - b, bl: always taken, target ImmTarget.
  - br: always taken, target RegTarget.
  - bltz: taken iff MSB=1.
  - bz: taken iff ALUzero=1.
  - bnz: taken iff ALUzero=0.
  - bcy: taken iff CarryFlag=1.
  - bncy: taken iff CarryFlag=0.
  - bcy/bncy use the registered flag value, never same-cycle ALUc_out.
- RUN, taken branch:
  - Next cycle: PC<=target, state<=FLUSH, counter loaded with FLUSH_CYCLES-1.
  - Flush=1 is registered and is high for exactly FLUSH_CYCLES cycles starting the cycle after resolution.
- RUN, not taken, or InstrValid=0: PC<=PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- bl: LinkWrEn=1 and LinkData=PC+4 (value of PC in the resolving cycle) for one cycle after resolution, whether or not a flush follows.
- Carry flag:
  - CarryFlag<=ALUc_out when InstrValid=1 and CarryWrEn=1, in RUN only.
  - A branch instruction with CarryWrEn=1 is illegal; branch evaluation still uses the old flag.
- FLUSH:
  - PC holds. InstrValid, CarryWrEn and HaltReq are ignored.
  - Counter decrements; at 0 the next state is RUN and Flush deasserts.
- HaltReq:
  - In RUN with InstrValid=1, HaltReq has priority over any branch.
  - Next cycle: state HALT, Halted=1, PC frozen at the halting instruction's PC+4.
  - Only reset exits HALT.
  - Flush=0 and LinkWrEn=0 while halted.
- Out-of-range FLUSH_CYCLES: clamp to 1.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds 16-bit saturating counters BrTotal and BrTaken, readable on extra output ports BrTotal[15:0] and BrTaken[15:0].
  - Increment on each resolved branch (BranchType 0001..1000) with InstrValid=1 in RUN.
  - Saturate at 16'hFFFF; reset to 0.
- Undefined: counters absent; the ports exist and are tied to 0.

Test Plan:
- Reset with RESET_PC=32'h100, release rst_n, idle 3 cycles -> PC=0x100,0x104,0x108,0x10C; Flush=0; CarryFlag=0.
- At PC=0x20 issue bz with ALUzero=1, ImmTarget=0x80, FLUSH_CYCLES=2 -> next PC=0x80, Flush=1 for 2 cycles, PC holds 0x80 during the flush, then 0x84.
- add with ALUc_out=1, CarryWrEn=1; next instruction bcy with ImmTarget=0x40 -> CarryFlag=1, branch taken to 0x40. Repeat with ALUc_out=0 -> not taken, PC+4.
- bl at PC=0x1C with ImmTarget=0x200 -> LinkWrEn pulse 1 cycle with LinkData=0x20; PC=0x200; Flush asserted.
- HaltReq together with a taken b at PC=0x50 -> Halted=1, PC frozen at 0x54, no Flush. Assert rst_n=0 mid-halt -> PC=RESET_PC, Halted=0 immediately.
- With BRANCH_STATS_EN: 3 taken + 2 untaken branches -> BrTotal=5, BrTaken=3. Preload near saturation -> value holds at 16'hFFFF.
